// File: rtl/result_display_pkg.sv
// Shared constants for the result display: segment patterns, digit count and refresh default.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package result_display_pkg;

   localparam int unsigned DIGIT_COUNT         = 4;
   localparam int unsigned REFRESH_DIV_DEFAULT = 100000;
   localparam int unsigned DATA_W              = 16;
   localparam int unsigned NIBBLE_W            = 4;
   localparam int unsigned SEG_W               = 7;
   localparam int unsigned IDX_W               = 2;
   localparam int unsigned PRESC_W             = 17;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   // Index n holds the pattern for hex digit n (listed F down to 0).
   localparam logic [15:0][SEG_W-1:0] SEG_HEX = {
      7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
      7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
      7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
      7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
   };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decode.
module hex_to_seg
   import result_display_pkg::*;
(
   input  logic [NIBBLE_W-1:0] hex_i,
   output logic [SEG_W-1:0]    seg_c
);

   assign seg_c = SEG_HEX[hex_i];

endmodule

// File: rtl/result_display.sv
// Holds the last upstream result and time-multiplexes it onto a 4-digit
// seven-segment display, with optional leading-zero blanking and overflow dp.
module result_display
   import result_display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] dataIn,
   input  logic              carryIn,
   input  logic              blankEn,
   output logic [3:0]        anode,
   output logic [SEG_W-1:0]  seg,
   output logic              dp
);

   logic [DATA_W-1:0]   held_q,  held_d;
   logic                ovf_q,   ovf_d;
   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic [IDX_W-1:0]    idx_q,   idx_d;
   logic [3:0]          anode_q, anode_d;
   logic [SEG_W-1:0]    seg_q,   seg_d;
   logic                dp_q,    dp_d;

   logic                tc_c;
   logic [DATA_W-1:0]   upper_c;
   logic [NIBBLE_W-1:0] nibble_c;
   logic [SEG_W-1:0]    hex_seg_c;
   logic                blank_c;

   assign tc_c     = (presc_q == PRESC_W'(REFRESH_DIV - 1));
   // held >> 4*idx gives both the selected nibble and the bits at and above it.
   assign upper_c  = held_q >> {idx_q, 2'b00};
   assign nibble_c = NIBBLE_W'(upper_c);
   assign blank_c  = blankEn && (idx_q != IDX_W'(0)) && (upper_c == '0);

   hex_to_seg u_hex_to_seg (
      .hex_i (nibble_c),
      .seg_c (hex_seg_c)
   );

   // Next-state: capture, prescaler, scan index and registered display outputs.
   always_comb begin
      held_d  = held_q;
      ovf_d   = ovf_q;
      presc_d = presc_q + PRESC_W'(1);
      idx_d   = idx_q;
      anode_d = 4'b1111;
      seg_d   = SEG_BLANK;
      dp_d    = 1'b1;

      if (load) begin
         held_d = dataIn;
         ovf_d  = carryIn;
      end

      if (tc_c) begin
         presc_d = '0;
         idx_d   = idx_q + IDX_W'(1);
      end

      if (!blank_c) begin
         anode_d = ~(4'b0001 << idx_q);
         seg_d   = hex_seg_c;
      end

      if ((idx_q == IDX_W'(DIGIT_COUNT - 1)) && ovf_q) begin
         dp_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         held_q  <= '0;
         ovf_q   <= 1'b0;
         presc_q <= '0;
         idx_q   <= '0;
         anode_q <= 4'b1111;
         seg_q   <= SEG_BLANK;
         dp_q    <= 1'b1;
      end else begin
         held_q  <= held_d;
         ovf_q   <= ovf_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         anode_q <= anode_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign anode = anode_q;
   assign seg   = seg_q;
   assign dp    = dp_q;

endmodule
